bus_fetch_reader: RTL and testbench
===================================

Name: bus_fetch_reader

Overview:
- Bus initiator that streams sequential words out of memory-mapped responders (ROM, RAM) over the shared bus.
- Drives addresses on read_bus, samples data_bus two read_clk edges later, and buffers the words in a small FIFO for a consumer such as the instruction decoder.
- Only the read side of the bus protocol is used. The block never drives data_bus or write_bus.

Parameters:
- WIDTH, 16, bus word and address width.
- DEPTH, 4, FIFO entries (power of two, at least 2).
- NULL_ADDR, 16'h0000, address driven when not fetching; system decode maps no responder here.

Ports:
- reset  input  1  asynchronous, active-high
- read_clk  input  1  bus read clock; all state changes on its rising edge
- start  input  1  one-cycle pulse: begin fetching at start_addr; flushes everything
- start_addr  input  WIDTH  first fetch address, sampled when start=1
- stop  input  1  one-cycle pulse: cease issuing addresses
- bus_grant  input  1  1 = this block may issue an address this cycle
- read_bus  output  WIDTH  registered address presented to responders
- data_bus  input  WIDTH  shared data bus, sampled only
- word_out  output  WIDTH  FIFO head word
- addr_out  output  WIDTH  address the head word was read from
- word_valid  output  1  FIFO non-empty
- word_ready  input  1  consumer pops head when word_valid & word_ready
- busy  output  1  in FETCH state, or any read still in flight

Behaviour:
- Reset (async): state=IDLE, read_bus=NULL_ADDR, FIFO empty, word_valid=0, busy=0, in-flight pipeline cleared, word_out/addr_out=0.
- Bus timing:
  - Edge E0: read_bus registered with A.
  - Edge E1: responder latches A and drives data.
  - Edge E2: block captures data_bus as word for A.
  - Issue-to-capture latency is 2 edges. One issue per cycle, fully pipelined.
- In-flight tracking: 2-stage shift register of {valid, addr}. Stage 0 is loaded on issue; stage 1 captures into the FIFO.
- States:
  - IDLE: read_bus=NULL_ADDR. start -> FETCH, next_addr=start_addr.
  - FETCH: issue when bus_grant=1 and (fifo_count + inflight_count) < DEPTH. On issue, read_bus=next_addr and next_addr+=1. Otherwise read_bus=NULL_ADDR with invalid stage-0 entry. stop -> DRAIN.
  - DRAIN: no issue, read_bus=NULL_ADDR. In-flight reads complete into the FIFO. When in-flight is empty -> IDLE.
- Address wrap: next_addr increments modulo 2^WIDTH (16'hFFFF -> 16'h0000). No halt at wrap.
- Credit rule guarantees a captured word never finds the FIFO full; overflow is impossible by construction.
- FIFO:
  - Simultaneous push and pop allowed at any count, including full and empty-with-push. Count is unchanged on simultaneous push+pop.
  - Pop on empty is ignored.
  - word_out/addr_out are stable while word_valid=1 and no pop occurs.
- start in any state, including mid-fetch or in DRAIN:
  - FIFO emptied.
  - Both in-flight stages invalidated, so older data is discarded.
  - next_addr=start_addr; state=FETCH.
  - The first issue of start_addr can occur on the same edge as start (if granted and credit allows).
- start and stop together: start wins.
- stop in IDLE: ignored.
- busy = (state==FETCH) | stage0.valid | stage1.valid.
- Reset mid-operation: immediate return to reset values; in-flight captures are lost.

Test Plan:
- Reset, then start with start_addr=16'h8000, bus_grant=1, word_ready=1, responder returns mem[a]=a^16'h5A5A -> read_bus 8000,8001,... on consecutive edges. First word_valid appears 2 edges after 8000 issued, with word_out=16'hDA5A, addr_out=16'h8000.
- word_ready=0 with DEPTH=4 -> exactly 4 addresses issued, then read_bus=NULL_ADDR. FIFO fills to 4, no word lost. Raise word_ready -> words pop in order, issuing resumes, steady 1 word/cycle.
- start_addr=16'hFFFE -> issues FFFE, FFFF, 0000, 0001; addr_out follows the same sequence.
- Mid-stream start to 16'h9000 while 2 reads are in flight -> neither stale word appears. Next word out is the word at 9000 with addr_out=9000.
- Toggle bus_grant 1,0,1,0 -> issues only on granted cycles, read_bus=NULL_ADDR otherwise. Output order stays strictly sequential.
- stop with 2 reads in flight -> both captured, busy drops 2 edges later, state returns to IDLE. Async reset asserted mid-FETCH -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_fetch_reader.sv
// rtl/bus_fetch_reader.sv - sequential bus read initiator with in-flight tracking and output FIFO
//
// Purpose: issues consecutive read addresses on read_bus, captures data_bus two
// read_clk edges after each issue, and queues {word, address} pairs for a consumer.
//
// Ports:
//   reset       async active-high reset
//   read_clk    bus read clock, all state changes on its rising edge
//   start       pulse: flush everything, begin fetching at start_addr
//   start_addr  first fetch address
//   stop        pulse: stop issuing, let in-flight reads complete
//   bus_grant   bus may be used for an issue this cycle
//   read_bus    registered address driven to responders
//   data_bus    shared data bus (sampled only)
//   word_out    FIFO head word
//   addr_out    address the head word was read from
//   word_valid  FIFO non-empty
//   word_ready  consumer pops head when word_valid & word_ready
//   busy        fetching, or a read still in flight
module bus_fetch_reader #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] NULL_ADDR = '0
) (
  input  logic             reset,
  input  logic             read_clk,
  input  logic             start,
  input  logic [WIDTH-1:0] start_addr,
  input  logic             stop,
  input  logic             bus_grant,
  output logic [WIDTH-1:0] read_bus,
  input  logic [WIDTH-1:0] data_bus,
  output logic [WIDTH-1:0] word_out,
  output logic [WIDTH-1:0] addr_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] next_addr_q, next_addr_d;
  logic [WIDTH-1:0] read_bus_q, read_bus_d;
  logic             s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s0_addr_q, s0_addr_d, s1_addr_q, s1_addr_d;
  logic [WIDTH-1:0] word_mem_q [DEPTH];
  logic [WIDTH-1:0] word_mem_d [DEPTH];
  logic [WIDTH-1:0] addr_mem_q [DEPTH];
  logic [WIDTH-1:0] addr_mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             issue, push, pop;
  logic [WIDTH-1:0] base_addr;
  logic [CW:0]      occupancy;

  // Credit: FIFO words plus reads in flight; an issue is only allowed while
  // this is below DEPTH, so a capture always finds a free FIFO slot.
  assign occupancy = {1'b0, count_q} + (CW + 1)'(s0_valid_q) + (CW + 1)'(s1_valid_q);

  always_comb begin
    state_d     = state_q;
    read_bus_d  = NULL_ADDR;
    s1_valid_d  = s0_valid_q;
    s1_addr_d   = s0_addr_q;
    word_mem_d  = word_mem_q;
    addr_mem_d  = addr_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    issue       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    base_addr   = next_addr_q;

    if (start) begin
      // Restart drops queued words and kills both in-flight stages; the
      // fresh start address may already be issued on this edge.
      state_d    = ST_FETCH;
      s1_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      base_addr  = start_addr;
      issue      = bus_grant;
    end else begin
      push = s1_valid_q;
      pop  = (count_q != '0) && word_ready;
      if (push) begin
        word_mem_d[wr_ptr_q] = data_bus;
        addr_mem_d[wr_ptr_q] = s1_addr_q;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      case (state_q)
        ST_FETCH: begin
          if (stop) begin
            state_d = ST_DRAIN;
          end else begin
            issue = bus_grant && (occupancy < DEPTH_C);
          end
        end
        // Stage 0 empty now means stage 1 is empty after this edge.
        ST_DRAIN: if (!s0_valid_q) state_d = ST_IDLE;
        ST_IDLE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    s0_valid_d  = issue;
    s0_addr_d   = base_addr;
    next_addr_d = issue ? base_addr + 1'b1 : base_addr;
    if (issue) begin
      read_bus_d = base_addr;
    end
  end

  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      read_bus_q  <= NULL_ADDR;
      s0_valid_q  <= 1'b0;
      s0_addr_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      read_bus_q  <= read_bus_d;
      s0_valid_q  <= s0_valid_d;
      s0_addr_q   <= s0_addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_mem_q  <= word_mem_d;
      addr_mem_q  <= addr_mem_d;
    end
  end

  assign read_bus   = read_bus_q;
  assign word_out   = word_mem_q[rd_ptr_q];
  assign addr_out   = addr_mem_q[rd_ptr_q];
  assign word_valid = (count_q != '0);
  assign busy       = (state_q == ST_FETCH) | s0_valid_q | s1_valid_q;

endmodule

// File: tb/tb_bus_fetch_reader.sv
// tb/tb_bus_fetch_reader.sv - self-checking bench for bus_fetch_reader
module tb_bus_fetch_reader;

  logic        reset = 1'b1;
  logic        read_clk = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = 16'h0;
  logic        stop = 1'b0;
  logic        bus_grant = 1'b0;
  logic [15:0] read_bus;
  logic [15:0] data_bus;
  logic [15:0] word_out;
  logic [15:0] addr_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  bus_fetch_reader #(.WIDTH(16), .DEPTH(4), .NULL_ADDR(16'h0000)) dut (
    .reset      (reset),
    .read_clk   (read_clk),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .bus_grant  (bus_grant),
    .read_bus   (read_bus),
    .data_bus   (data_bus),
    .word_out   (word_out),
    .addr_out   (addr_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  always #5 read_clk = ~read_clk;

  // Responder: latches the address one edge after it is driven, returns a ^ 5A5A.
  logic [15:0] resp_addr = 16'h0;
  always @(posedge read_clk) resp_addr <= read_bus;
  assign data_bus = resp_addr ^ 16'h5A5A;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending reads as a two-slot pipeline, the output FIFO as a
  // queue of addresses (the word is always addr ^ 5A5A for this responder).
  logic [15:0] m_fifo[$];
  bit          m_v0 = 0, m_v1 = 0;
  logic [15:0] m_a0 = 16'h0, m_a1 = 16'h0, m_na = 16'h0, m_rb = 16'h0;
  int          m_st = 0;  // 0 idle, 1 fetch, 2 drain

  always @(posedge read_clk or posedge reset) begin
    int occ;
    bit go;
    if (reset) begin
      m_fifo.delete();
      m_v0 = 0; m_v1 = 0; m_rb = 16'h0; m_st = 0;
    end else if (start) begin
      m_fifo.delete();
      m_v1 = 0;
      m_st = 1;
      m_v0 = bus_grant;
      m_a0 = start_addr;
      m_rb = bus_grant ? start_addr : 16'h0;
      m_na = bus_grant ? start_addr + 16'd1 : start_addr;
    end else begin
      occ = m_fifo.size() + int'(m_v0) + int'(m_v1);
      if (m_fifo.size() > 0 && word_ready) void'(m_fifo.pop_front());
      if (m_v1) m_fifo.push_back(m_a1);
      go = (m_st == 1) && !stop && bus_grant && (occ < 4);
      m_v1 = m_v0;
      m_a1 = m_a0;
      m_v0 = go;
      m_a0 = m_na;
      m_rb = go ? m_na : 16'h0;
      if (go) m_na = m_na + 16'd1;
      if (m_st == 1 && stop) m_st = 2;
      else if (m_st == 2 && !m_v0 && !m_v1) m_st = 0;
    end
  end

  always @(negedge read_clk) begin
    chk("read_bus", read_bus, m_rb);
    chk("word_valid", 16'(word_valid), 16'(m_fifo.size() > 0));
    chk("busy", 16'(busy), 16'(m_st == 1 || m_v0 || m_v1));
    if (m_fifo.size() > 0) begin
      chk("addr_out", addr_out, m_fifo[0]);
      chk("word_out", word_out, m_fifo[0] ^ 16'h5A5A);
    end
  end

  task automatic step();
    @(negedge read_clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset values
    step();
    chk("rst_read_bus", read_bus, 16'h0000);
    chk("rst_valid", 16'(word_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_word_out", word_out, 16'h0000);
    chk("rst_addr_out", addr_out, 16'h0000);
    reset = 1'b0;
    step();

    // Streaming from 8000, first word 2 edges after issue
    start = 1'b1; start_addr = 16'h8000; bus_grant = 1'b1; word_ready = 1'b1;
    step(); start = 1'b0;
    chk("s1_issue0", read_bus, 16'h8000);
    step();
    chk("s1_issue1", read_bus, 16'h8001);
    chk("s1_not_yet", 16'(word_valid), 16'h0);
    step();
    chk("s1_issue2", read_bus, 16'h8002);
    chk("s1_valid", 16'(word_valid), 16'h1);
    chk("s1_word", word_out, 16'hDA5A);
    chk("s1_addr", addr_out, 16'h8000);
    steps(4);

    // Back-pressure: exactly DEPTH issues, then FIFO full and held
    start = 1'b1; start_addr = 16'h1000; word_ready = 1'b0;
    step(); start = 1'b0;
    chk("bp_issue0", read_bus, 16'h1000);
    steps(5);
    chk("bp_null", read_bus, 16'h0000);
    chk("bp_valid", 16'(word_valid), 16'h1);
    chk("bp_head_addr", addr_out, 16'h1000);
    chk("bp_head_word", word_out, 16'h4A5A);
    word_ready = 1'b1;
    steps(12);

    // Address wrap
    start = 1'b1; start_addr = 16'hFFFE;
    step(); start = 1'b0;
    chk("wrap0", read_bus, 16'hFFFE);
    step(); chk("wrap1", read_bus, 16'hFFFF);
    step(); chk("wrap2", read_bus, 16'h0000);
    step(); chk("wrap3", read_bus, 16'h0001);
    steps(3);

    // Restart mid-stream with reads in flight
    start = 1'b1; start_addr = 16'h9000;
    step(); start = 1'b0;
    chk("rs_flush0", 16'(word_valid), 16'h0);
    step();
    chk("rs_flush1", 16'(word_valid), 16'h0);
    step();
    chk("rs_valid", 16'(word_valid), 16'h1);
    chk("rs_addr", addr_out, 16'h9000);
    chk("rs_word", word_out, 16'hCA5A);
    steps(3);

    // Grant toggling
    start = 1'b1; start_addr = 16'hA000; bus_grant = 1'b1;
    step(); start = 1'b0; bus_grant = 1'b0;
    chk("gt0", read_bus, 16'hA000);
    step(); bus_grant = 1'b1; chk("gt1", read_bus, 16'h0000);
    step(); bus_grant = 1'b0; chk("gt2", read_bus, 16'hA001);
    step(); bus_grant = 1'b1; chk("gt3", read_bus, 16'h0000);
    step(); chk("gt4", read_bus, 16'hA002);
    steps(2);

    // Stop with two reads in flight
    stop = 1'b1;
    step(); stop = 1'b0;
    chk("stop_busy1", 16'(busy), 16'h1);
    chk("stop_null", read_bus, 16'h0000);
    step();
    chk("stop_busy0", 16'(busy), 16'h0);
    steps(3);

    // Stop in idle is ignored
    stop = 1'b1;
    step(); stop = 1'b0;
    chk("idle_stop_busy", 16'(busy), 16'h0);
    chk("idle_stop_bus", read_bus, 16'h0000);

    // Start and stop together: start wins
    start = 1'b1; stop = 1'b1; start_addr = 16'hB000;
    step(); start = 1'b0; stop = 1'b0;
    chk("ss_issue", read_bus, 16'hB000);
    chk("ss_busy", 16'(busy), 16'h1);
    steps(4);

    // Asynchronous reset mid-fetch
    #2 reset = 1'b1;
    #1;
    chk("ar_read_bus", read_bus, 16'h0000);
    chk("ar_valid", 16'(word_valid), 16'h0);
    chk("ar_busy", 16'(busy), 16'h0);
    chk("ar_word_out", word_out, 16'h0000);
    chk("ar_addr_out", addr_out, 16'h0000);
    step();
    reset = 1'b0;
    start = 1'b1; start_addr = 16'hC000;
    step(); start = 1'b0;
    chk("post_rst_issue", read_bus, 16'hC000);
    steps(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
